// File: rtl/instr_encoder.sv
// RV32I program loader: turns decoded instruction descriptors into machine words
// and streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_class,
    input  logic [3:0]            in_alu,
    input  logic                  in_addr_mode,
    input  logic [2:0]            in_br_funct3,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CL_R      = 3'd0;
    localparam logic [2:0] CL_IALU   = 3'd1;
    localparam logic [2:0] CL_LOAD   = 3'd2;
    localparam logic [2:0] CL_JALR   = 3'd3;
    localparam logic [2:0] CL_STORE  = 3'd4;
    localparam logic [2:0] CL_BRANCH = 3'd5;
    localparam logic [2:0] CL_LUI    = 3'd6;
    localparam logic [2:0] CL_JAL    = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    function automatic logic [2:0] alu_funct3(input logic [3:0] alu);
        logic [2:0] f3;
        case (alu)
            ALU_ADD, ALU_SUB: f3 = 3'b000;
            ALU_SLL:          f3 = 3'b001;
            ALU_SLT:          f3 = 3'b010;
            ALU_SLTU:         f3 = 3'b011;
            ALU_XOR:          f3 = 3'b100;
            ALU_SRL, ALU_SRA: f3 = 3'b101;
            ALU_OR:           f3 = 3'b110;
            ALU_AND:          f3 = 3'b111;
            default:          f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic logic [6:0] alu_funct7(input logic [3:0] alu);
        logic [6:0] f7;
        case (alu)
            ALU_SUB, ALU_SRA: f7 = 7'b0100000;
            default:          f7 = 7'b0000000;
        endcase
        return f7;
    endfunction

    function automatic logic desc_legal(input logic [2:0] cls, input logic [3:0] alu,
                                        input logic [2:0] bf3);
        logic ok;
        case (cls)
            CL_R:      ok = (alu <= ALU_SLTU);
            CL_IALU:   ok = (alu <= ALU_SLTU) && (alu != ALU_SUB);
            CL_BRANCH: ok = (bf3 != 3'b010) && (bf3 != 3'b011);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode(input logic [2:0] cls, input logic [3:0] alu,
                                           input logic mode, input logic [2:0] bf3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [31:0] imm);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        f3 = alu_funct3(alu);
        f7 = alu_funct7(alu);
        case (cls)
            CL_R:      w = {f7, rs2, rs1, f3, rd, OP_R};
            CL_IALU: begin
                // shift-immediates carry funct7 in the upper immediate bits
                if (alu == ALU_SLL || alu == ALU_SRL || alu == ALU_SRA) begin
                    w = {f7, imm[4:0], rs1, f3, rd, OP_IALU};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, OP_IALU};
                end
            end
            CL_LOAD:   w = {imm[11:0], rs1, (mode ? 3'b100 : 3'b010), rd, OP_LOAD};
            CL_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            CL_STORE:  w = {imm[11:5], rs2, rs1, (mode ? 3'b000 : 3'b010), imm[4:0], OP_STORE};
            CL_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, bf3, imm[4:1], imm[11], OP_BRANCH};
            CL_LUI:    w = {imm[31:12], rd, OP_LUI};
            CL_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default:   w = 32'd0;
        endcase
        return w;
    endfunction

    state_t                state_r, state_s;
    logic                  stg_valid_r, stg_valid_s;
    logic [2:0]            stg_class_r;
    logic [3:0]            stg_alu_r;
    logic                  stg_mode_r;
    logic [2:0]            stg_bf3_r;
    logic [4:0]            stg_rd_r, stg_rs1_r, stg_rs2_r;
    logic [31:0]           stg_imm_r;
    logic                  stg_last_r;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [ADDR_WIDTH:0]   count_r, count_s;
    logic                  err_r, err_s;
    logic                  in_ready_r, in_ready_s;
    logic                  wr_en_r, wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [31:0]           wr_data_r, wr_data_s;
    logic                  busy_r, done_r;
    logic                  stg_legal_s, in_legal_s, issue_s, final_s, accept_s;
    logic [31:0]           stg_word_s;

    // Next-state, write-port and handshake decisions for the coming edge.
    always_comb begin
        stg_legal_s = desc_legal(stg_class_r, stg_alu_r, stg_bf3_r);
        in_legal_s  = desc_legal(in_class, in_alu, in_br_funct3);
        stg_word_s  = encode(stg_class_r, stg_alu_r, stg_mode_r, stg_bf3_r,
                             stg_rd_r, stg_rs1_r, stg_rs2_r, stg_imm_r);
        issue_s     = stg_valid_r && stg_legal_s;
        final_s     = stg_valid_r && (stg_last_r || (stg_legal_s && (addr_r == ADDR_TOP)));
        accept_s    = in_valid && in_ready_r;
        state_s     = state_r;
        addr_s      = addr_r;
        count_s     = count_r;
        err_s       = err_r;
        stg_valid_s = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    addr_s  = ADDR_BASE;
                    count_s = '0;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = addr_r;
                    wr_data_s = stg_word_s;
                    count_s   = count_r + CNT_ONE;
                    if (addr_r == ADDR_TOP) begin
                        addr_s = addr_r;
                    end else begin
                        addr_s = addr_r + ADDR_ONE;
                    end
                end else if (stg_valid_r) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (final_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
                if (accept_s) begin
                    stg_valid_s = 1'b1;
                end else begin
                    stg_valid_s = 1'b0;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        // stop accepting while the program's closing descriptor waits in the stage
        if ((state_s == ST_RUN) &&
            !(stg_valid_s && (in_last || (in_legal_s && (addr_s == ADDR_TOP))))) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // State, stage register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            stg_valid_r <= 1'b0;
            stg_class_r <= 3'd0;
            stg_alu_r   <= 4'd0;
            stg_mode_r  <= 1'b0;
            stg_bf3_r   <= 3'd0;
            stg_rd_r    <= 5'd0;
            stg_rs1_r   <= 5'd0;
            stg_rs2_r   <= 5'd0;
            stg_imm_r   <= 32'd0;
            stg_last_r  <= 1'b0;
            addr_r      <= '0;
            count_r     <= '0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            stg_valid_r <= stg_valid_s;
            addr_r      <= addr_s;
            count_r     <= count_s;
            err_r       <= err_s;
            in_ready_r  <= in_ready_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
            if (accept_s) begin
                stg_class_r <= in_class;
                stg_alu_r   <= in_alu;
                stg_mode_r  <= in_addr_mode;
                stg_bf3_r   <= in_br_funct3;
                stg_rd_r    <= in_rd;
                stg_rs1_r   <= in_rs1;
                stg_rs2_r   <= in_rs2;
                stg_imm_r   <= in_imm;
                stg_last_r  <= in_last;
            end
        end
    end

    assign in_ready = in_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign count    = count_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus a 4-word
// instance for the memory-full case, checked against hand-computed words.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, in_valid, in_addr_mode, in_last;
    logic [2:0]  in_class, in_br_funct3;
    logic [3:0]  in_alu;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic        in_ready_a, wr_en_a, busy_a, done_a, err_a;
    logic [7:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [8:0]  count_a;
    logic        in_ready_b, wr_en_b, busy_b, done_b, err_b;
    logic [1:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [2:0]  count_b;

    instr_encoder u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_class(in_class), .in_alu(in_alu), .in_addr_mode(in_addr_mode),
        .in_br_funct3(in_br_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .count(count_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    instr_encoder #(.ADDR_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_class(in_class), .in_alu(in_alu), .in_addr_mode(in_addr_mode),
        .in_br_funct3(in_br_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .count(count_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [7:0]  qa_addr[$];
    logic [31:0] qa_data[$];
    int          qa_cyc[$];
    logic [1:0]  qb_addr[$];
    logic [31:0] qb_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en_a) begin
            qa_addr.push_back(wr_addr_a);
            qa_data.push_back(wr_data_a);
            qa_cyc.push_back(cyc);
        end
        if (wr_en_b) begin
            qb_addr.push_back(wr_addr_b);
            qb_data.push_back(wr_data_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_qa();
        qa_addr.delete();
        qa_data.delete();
        qa_cyc.delete();
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic [2:0] cls, input logic [3:0] alu, input logic mode,
                          input logic [2:0] bf3, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        bit acc = 1'b0;
        in_class = cls; in_alu = alu; in_addr_mode = mode; in_br_funct3 = bf3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            if (in_ready_a) acc = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("accept_a", 32'(acc), 32'd1);
    endtask

    task automatic wait_done_a();
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step();
            if (done_a) seen = 1'b1;
        end
        chk("done_a_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_w[4];
        int c0;
        int acc;
        bit saw_done;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_class = 3'd0;
        in_alu = 4'd0; in_addr_mode = 1'b0; in_br_funct3 = 3'd0; in_rd = 5'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; in_last = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_wr_en",    32'(wr_en_a),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr_a),  32'd0);
        chk("rst_wr_data",  wr_data_a,       32'd0);
        chk("rst_count",    32'(count_a),    32'd0);
        chk("rst_flags",    32'({busy_a, done_a, err_a}), 32'd0);
        rst = 1'b0;
        step();

        // basic R-type with last
        pulse_start_a();
        chk("start_busy",  32'(busy_a),     32'd1);
        chk("start_ready", 32'(in_ready_a), 32'd1);
        send_a(3'd0, 4'b0000, 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        chk("last_in_stage_ready", 32'(in_ready_a), 32'd0);
        chk("no_write_yet", 32'(wr_en_a), 32'd0);
        step();
        chk("basic_wr_en",   32'(wr_en_a),   32'd1);
        chk("basic_wr_addr", 32'(wr_addr_a), 32'd0);
        chk("basic_wr_data", wr_data_a,      32'h002081B3);
        chk("basic_done",    32'(done_a),    32'd1);
        chk("basic_count",   32'(count_a),   32'd1);
        step();
        chk("basic_idle", 32'({wr_en_a, done_a, busy_a}), 32'd0);

        // back-to-back stream
        clear_qa();
        pulse_start_a();
        send_a(3'd0, 4'b0001, 1'b0, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
        send_a(3'd1, 4'b0000, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
        send_a(3'd4, 4'b0000, 1'b0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send_a(3'd6, 4'b0000, 1'b0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        wait_done_a();
        chk("stream_count", 32'(count_a), 32'd4);
        step();
        exp_w[0] = 32'h407302B3; exp_w[1] = 32'hFFF00093;
        exp_w[2] = 32'h0020A423; exp_w[3] = 32'h123452B7;
        chk("stream_nwrites", 32'(qa_data.size()), 32'd4);
        if (qa_data.size() == 4) begin
            c0 = qa_cyc[0];
            for (int i = 0; i < 4; i++) begin
                chk("stream_addr", 32'(qa_addr[i]), 32'(i));
                chk("stream_data", qa_data[i], exp_w[i]);
                chk("stream_consecutive", 32'(qa_cyc[i] - c0), 32'(i));
            end
        end

        // other formats: srai, jal, lbu, branch with negative offset
        clear_qa();
        pulse_start_a();
        send_a(3'd1, 4'b0110, 1'b0, 3'd0, 5'd2, 5'd3, 5'd0, 32'd5, 1'b0);
        send_a(3'd7, 4'b0000, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
        send_a(3'd2, 4'b0000, 1'b1, 3'd0, 5'd4, 5'd2, 5'd0, 32'd16, 1'b0);
        send_a(3'd5, 4'b0000, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1);
        wait_done_a();
        step();
        exp_w[0] = 32'h4051D113; exp_w[1] = 32'h008000EF;
        exp_w[2] = 32'h01014203; exp_w[3] = 32'hFE000EE3;
        chk("fmt_nwrites", 32'(qa_data.size()), 32'd4);
        if (qa_data.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("fmt_data", qa_data[i], exp_w[i]);
        end

        // illegal I-ALU sub followed by legal last
        clear_qa();
        pulse_start_a();
        send_a(3'd1, 4'b0001, 1'b0, 3'd0, 5'd1, 5'd1, 5'd0, 32'd5, 1'b0);
        send_a(3'd0, 4'b0010, 1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        wait_done_a();
        chk("illegal_err",   32'(err_a),   32'd1);
        chk("illegal_count", 32'(count_a), 32'd1);
        step();
        chk("illegal_nwrites", 32'(qa_data.size()), 32'd1);
        if (qa_data.size() == 1) begin
            chk("illegal_addr", 32'(qa_addr[0]), 32'd0);
            chk("illegal_data", qa_data[0],      32'h003170B3);
        end
        chk("err_sticky_idle", 32'(err_a), 32'd1);
        pulse_start_a();
        chk("start_clears_err", 32'(err_a), 32'd0);
        send_a(3'd5, 4'b0000, 1'b0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        wait_done_a();
        chk("illegal_last_err",   32'(err_a),   32'd1);
        chk("illegal_last_count", 32'(count_a), 32'd0);
        step();
        chk("illegal_last_nowrite", 32'(qa_data.size()), 32'd1);

        // memory full on the 4-word instance: six addi offered, no last
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        acc = 0;
        saw_done = 1'b0;
        in_class = 3'd1; in_alu = 4'b0000; in_addr_mode = 1'b0; in_br_funct3 = 3'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; in_last = 1'b0;
        in_rd = 5'd1;
        in_valid = 1'b1;
        for (int t = 0; t < 12; t++) begin
            bit rdy;
            rdy = in_ready_b;
            step();
            if (rdy) begin
                acc++;
                in_rd = 5'(acc + 1);
            end
            if (done_b) begin
                saw_done = 1'b1;
                chk("full_count", 32'(count_b), 32'd4);
            end
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(acc),      32'd4);
        chk("full_done",     32'(saw_done), 32'd1);
        chk("full_nwrites",  32'(qb_data.size()), 32'd4);
        if (qb_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("full_addr", 32'(qb_addr[i]), 32'(i));
                chk("full_data", qb_data[i], (32'(i + 1) << 7) | 32'h13);
            end
        end
        chk("full_idle", 32'({busy_b, in_ready_b}), 32'd0);

        // reset in the cycle after an acceptance drops the pending write
        clear_qa();
        pulse_start_a();
        send_a(3'd0, 4'b0000, 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send_a(3'd0, 4'b0001, 1'b0, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
        chk("pre_rst_wr_en", 32'(wr_en_a), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_wr_en", 32'(wr_en_a),    32'd0);
        chk("rst_mid_busy",  32'(busy_a),     32'd0);
        chk("rst_mid_count", 32'(count_a),    32'd0);
        chk("rst_mid_ready", 32'(in_ready_a), 32'd0);
        rst = 1'b0;
        step(); step();
        chk("rst_dropped_write", 32'(qa_data.size()), 32'd1);
        clear_qa();
        pulse_start_a();
        send_a(3'd6, 4'b0000, 1'b0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        wait_done_a();
        step();
        chk("restart_nwrites", 32'(qa_data.size()), 32'd1);
        if (qa_data.size() == 1) begin
            chk("restart_addr", 32'(qa_addr[0]), 32'd0);
            chk("restart_data", qa_data[0],      32'h123452B7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder, the inverse of the decode-stage control unit. It accepts decoded instruction descriptors over a valid/ready handshake: instruction class, ALU operation in the core's ALUControl encoding, byte/word address mode, register indices and a 32-bit immediate. From each descriptor it builds the 32-bit machine word and writes it through a one-cycle write port into instruction memory at an auto-incrementing word address. It sits beside the core's instruction memory as the program loader for self-test and bring-up.

## Interface
- ADDR_WIDTH, 8, width of the word address (memory depth 2^ADDR_WIDTH words)
- BASE_ADDR, 0, first word address written after `start`

- clk  in  1  clock; one clock domain, all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  pulse; sampled only in IDLE
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted on cycles where in_valid && in_ready
- in_class  in  3  0=R, 1=I-ALU, 2=LOAD, 3=JALR, 4=STORE, 5=BRANCH, 6=LUI, 7=JAL
- in_alu  in  4  ALUControl code, used for R and I-ALU only
- in_addr_mode  in  1  LOAD/STORE width: 1=byte (LBU/SB), 0=word (LW/SW)
- in_br_funct3  in  3  branch condition, BRANCH only
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, interpreted as described under Operation
- in_last  in  1  marks the final descriptor of the program
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_WIDTH  word address
- wr_data  out  32  encoded instruction
- count  out  ADDR_WIDTH+1  words written since `start`
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the program is complete
- err  out  1  sticky; set when an illegal descriptor is seen, cleared by `start`

## Operation
- **State machine.** States are IDLE, RUN and DONE.
  - IDLE→RUN on `start`. On that transition: address←BASE_ADDR, count←0, err←0.
  - RUN→DONE when the write of an `in_last` descriptor issues, or when a write lands on address 2^ADDR_WIDTH−1.
  - DONE→IDLE unconditionally on the next cycle; `done`=1 only while in DONE.
- **in_ready.** Equals 1 in RUN, except in the cycle where the accepted `in_last` descriptor, or the write to the final address, is in the stage register. It is 0 in IDLE and DONE.
- **Pipeline.** A single stage register captures the descriptor on acceptance. The encoded word is registered to wr_data/wr_addr/wr_en one cycle later. No backpressure from memory.
- **Address and count.** After each issued write: address+1, count+1. The address never wraps; completion at the top address forces DONE.
- **Opcodes:** R=0110011, I-ALU=0010011, LOAD=0000011, JALR=1100111, STORE=0100011, BRANCH=1100011, LUI=0110111, JAL=1101111.
- **ALU code to funct3/funct7:**
  - 0000 add → 000/0x00
  - 0001 sub → 000/0x20 (R only)
  - 0101 sll → 001
  - 1000 slt → 010
  - 1001 sltu → 011
  - 0100 xor → 100
  - 0111 srl → 101/0x00
  - 0110 sra → 101/0x20
  - 0011 or → 110
  - 0010 and → 111
- **I-ALU immediates.** For sll/srl/sra, [31:25]=funct7 and [24:20]=imm[4:0]. Otherwise [31:20]=imm[11:0].
- **LOAD.** funct3 = 100 (byte) or 010 (word). I-format.
- **JALR.** funct3=000. I-format.
- **STORE.** funct3 = 000 (byte) or 010 (word). [31:25]=imm[11:5], [11:7]=imm[4:0].
- **BRANCH.** funct3=in_br_funct3. [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. imm[0] is ignored.
- **LUI.** [31:12]=imm[31:12].
- **JAL.** [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. imm[0] is ignored.
- **Unused register fields.** Fields the format does not use are taken from the inputs as-is, e.g. rs2 in I-format is overwritten by the immediate.
- **Illegal descriptors:**
  - sub in I-ALU
  - undefined ALU codes (1010–1111)
  - branch funct3 010 or 011

  An illegal descriptor is accepted but not written: err←1, address and count unchanged. If it carries `in_last`, the FSM still goes to DONE.

## Timing
- **Reset values.** in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, busy=0, done=0, err=0. Stage register is invalid, state is IDLE.
- **Latency.** Acceptance in cycle N → wr_en=1 in cycle N+1 with wr_addr=address, wr_data=encoding. Sustained throughput is 1 word per cycle.
- **wr_en.** High for exactly one cycle per legal descriptor.
- **start outside IDLE.** `start` in RUN or DONE is ignored.
- **Reset mid-operation.** Reset in any cycle drops a pending stage-register write, so no wr_en follows; all outputs return to reset values the next cycle.
- **in_valid outside RUN.** in_valid while in_ready=0 has no effect; the descriptor must be held.

## Test plan
- **Basic R-type.** start; R add rd=3 rs1=1 rs2=2 with last → wr_addr=0, wr_data=0x002081B3 one cycle after acceptance; done pulses; count=1.
- **Back-to-back stream.** Issue on consecutive cycles:
  - R sub rd=5 rs1=6 rs2=7 → 0x407302B3 at addr 0
  - I-ALU add rd=1 rs1=0 imm=−1 → 0xFFF00093 at addr 1
  - STORE word rs1=1 rs2=2 imm=8 → 0x0020A423 at addr 2
  - LUI rd=5 imm=0x12345000 (last) → 0x123452B7 at addr 3

  Required: wr_en high on four consecutive cycles, count=4.
- **Branch immediate scrambling.** BRANCH funct3=000 rs1=0 rs2=0 imm=−4 → 0xFE000EE3.
- **Illegal descriptors.** I-ALU with alu=0001, then a legal descriptor with last → err=1; no write for the illegal one; legal word written at addr 0; count=1. A subsequent `start` clears err.
- **Full memory.** ADDR_WIDTH=2, six descriptors offered without last:
  - four writes to addr 0–3, then DONE
  - in_ready low for the 5th and 6th descriptors
  - count=4
- **Reset during stream.** Assert rst in the cycle after an acceptance → no wr_en; busy=0, count=0 next cycle; a new `start` writes from BASE_ADDR.
